uart_tx_arb: RTL

- Round-robin arbiter and sequencer that shares one buffered UART transmitter between NUM_REQ byte-stream requesters.
- Each requester presents bytes with a valid/ready handshake plus a last flag.
- A granted requester holds the transmitter until it sends a byte marked last, or until it stalls longer than HOLD_TIMEOUT.
- Sits between debug/log sources and the transmitter. It drives tx_data/tx_en and paces itself with tx_busy.

---
 rtl/uart_tx_arb_if.sv | 25 ++
 rtl/uart_tx_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester, transmitter and status signals of the shared UART transmit arbiter.
// The arbiter uses the slave view; requesters and transmitter model use the master view.
interface uart_tx_arb_if #(
   parameter int NUM_REQ = 4
);
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_en;
   logic                 tx_busy;
   logic [NUM_REQ-1:0]   grant;
   logic                 timeout_err;

   modport slave (
      input  req_data, req_valid, req_last, tx_busy,
      output req_ready, tx_data, tx_en, grant, timeout_err
   );

   modport master (
      output req_data, req_valid, req_last, tx_busy,
      input  req_ready, tx_data, tx_en, grant, timeout_err
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin, message-locked sharing of one UART transmitter; valid->tx_en is one cycle.
// Each requester is backpressured by a one-cycle req_ready strobe; the transmitter paces via tx_busy.
module uart_tx_arb #(
   parameter int NUM_REQ      = 4,
   parameter int ACK_TIMEOUT  = 8,
   parameter int HOLD_TIMEOUT = 64
) (
   input  logic         i_clk,
   input  logic         i_resetn,
   uart_tx_arb_if.slave io_bus
);
   localparam int IW   = $clog2(NUM_REQ);
   localparam int MAXT = (ACK_TIMEOUT > HOLD_TIMEOUT) ? ACK_TIMEOUT : HOLD_TIMEOUT;
   localparam int CW   = $clog2(MAXT + 1);
   localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_HOLD
   } state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [IW-1:0]      r_idx;
   logic [IW-1:0]      r_rr;
   logic [7:0]         r_tx_data;
   logic               r_last_q;
   logic [CW-1:0]      r_cnt;

   state_t             w_nstate;
   logic               w_any;
   logic [IW-1:0]      w_pick;
   logic [IW-1:0]      w_cand;
   logic [IW-1:0]      w_load_idx;
   logic [IW-1:0]      w_rr_next;
   logic [7:0]         w_bytes [NUM_REQ];
   logic               w_gvalid;
   logic               w_load;
   logic               w_release;
   logic               w_cnt_clr;
   logic               w_cnt_inc;
   logic               w_timeout;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_bytes[i] = io_bus.req_data[8*i +: 8];
      end
   end

   // First valid requester at or after the round-robin pointer, wrapping.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = IW'((int'(r_rr) + k) % NUM_REQ);
         if (!w_any && io_bus.req_valid[w_cand]) begin
            w_any  = 1'b1;
            w_pick = w_cand;
         end
      end
   end

   assign w_gvalid   = io_bus.req_valid[r_idx];
   assign w_load_idx = (r_state == S_IDLE) ? w_pick : r_idx;
   assign w_rr_next  = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nstate;
      end
   end

   always_comb begin
      w_nstate  = r_state;
      w_load    = 1'b0;
      w_release = 1'b0;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_load   = 1'b1;
               w_nstate = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt_clr = 1'b1;
            w_nstate  = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (io_bus.tx_busy) begin
               w_nstate = S_WAIT_DONE;
            end else if (r_cnt >= ACK_LIM) begin
               // No ack: treat the byte as sent and carry on.
               w_timeout = 1'b1;
               w_nstate  = S_WAIT_DONE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!io_bus.tx_busy) begin
               if (r_last_q) begin
                  w_release = 1'b1;
                  w_nstate  = S_IDLE;
               end else if (w_gvalid) begin
                  w_load   = 1'b1;
                  w_nstate = S_ISSUE;
               end else begin
                  w_cnt_clr = 1'b1;
                  w_nstate  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_gvalid) begin
               w_load   = 1'b1;
               w_nstate = S_ISSUE;
            end else if (r_cnt >= HOLD_LIM) begin
               w_timeout = 1'b1;
               w_release = 1'b1;
               w_nstate  = S_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: begin
            w_nstate = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_grant   <= '0;
         r_idx     <= '0;
         r_rr      <= '0;
         r_tx_data <= '0;
         r_last_q  <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (w_load) begin
            r_tx_data <= w_bytes[w_load_idx];
            r_last_q  <= io_bus.req_last[w_load_idx];
            if (r_state == S_IDLE) begin
               r_idx   <= w_pick;
               r_grant <= ONE_HOT0 << w_pick;
            end
         end
         if (w_release) begin
            r_grant <= '0;
            r_rr    <= w_rr_next;
         end
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign io_bus.tx_en       = (r_state == S_ISSUE);
   assign io_bus.req_ready   = r_grant & {NUM_REQ{r_state == S_ISSUE}};
   assign io_bus.tx_data     = r_tx_data;
   assign io_bus.grant       = r_grant;
   assign io_bus.timeout_err = w_timeout;
endmodule
